// File: rtl/fpu_share_arb.sv
// -----------------------------------------------------------------------------
// fpu_share_arb : round-robin sharer of one en/valid/idle FPU unit among NREQ
// requesters; optional WAIT watchdog with FPU_SHARE_ARB_TIMEOUT_EN. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module fpu_share_arb #(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_x1,
  output logic [NREQ-1:0]   resp_valid,
  output logic [31:0]       resp_y,
`ifdef FPU_SHARE_ARB_TIMEOUT_EN
  output logic              resp_err,
`endif
  output logic              busy,
  output logic              unit_en,
  output logic [31:0]       unit_x1,
  input  logic              unit_valid,
  input  logic              unit_idle,
  input  logic [31:0]       unit_y
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   ptr, tag, win;
  logic            found;
  logic            accept;
  logic            tmo;

  // First valid requester at or above ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        win   = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  // rstn gating keeps req_ready low while reset is held.
  assign accept = rstn && (state == S_IDLE) && unit_idle && found;

`ifdef FPU_SHARE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wcnt;
  logic          err_q;

  assign tmo = (state == S_WAIT) && !unit_valid && (wcnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == S_ISSUE) begin
        wcnt  <= '0;
        err_q <= 1'b0;
      end else if (state == S_WAIT) begin
        wcnt <= wcnt + CW'(1);
        if (tmo) err_q <= 1'b1;
      end
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    resp_valid = '0;
    unit_en    = 1'b0;
    busy       = (state != S_IDLE);
`ifdef FPU_SHARE_ARB_TIMEOUT_EN
    resp_err   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (accept) begin
          req_ready = ONE << win;
          state_nx  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        unit_en  = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (unit_valid || tmo) state_nx = S_RESP;
      end
      S_RESP: begin
        resp_valid = ONE << tag;
`ifdef FPU_SHARE_ARB_TIMEOUT_EN
        resp_err   = err_q;
`endif
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr     <= '0;
      tag     <= '0;
      unit_x1 <= '0;
      resp_y  <= '0;
    end else begin
      if (accept) begin
        unit_x1 <= req_x1[32*win +: 32];
        tag     <= win;
        ptr     <= (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
      end
      if (state == S_WAIT) begin
        if (unit_valid) resp_y <= unit_y;
        else if (tmo)   resp_y <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/fpu_share_arb.md
Name: fpu_share_arb

Overview:
- Round-robin arbiter/sequencer that shares one multi-cycle FPU unit (en/valid/idle handshake, e.g. ftoi) among NREQ requesters.
- Accepts one operand per grant, pulses the unit's en, waits for its valid, and returns the result to the granted requester only.
- Sits between the core's issue ports (integer pipe, FP pipe, ...) and a single FPU conversion unit.

Parameters:
- NREQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 16, watchdog limit in WAIT (used only with FPU_SHARE_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester request; held until accepted.
- req_ready  out  NREQ  one-hot accept strobe; transfer when req_valid[i] and req_ready[i].
- req_x1  in  NREQ*32  operands; requester i at bits [32*i+31:32*i].
- resp_valid  out  NREQ  one-hot, one-cycle result pulse to the owning requester.
- resp_y  out  32  result; valid only while any resp_valid bit is high.
- busy  out  1  high in any state other than IDLE.
- unit_en  out  1  one-cycle start pulse to the FPU unit.
- unit_x1  out  32  registered operand to the unit.
- unit_valid  in  1  unit result pulse.
- unit_idle  in  1  unit can accept en.
- unit_y  in  32  unit result.

Behaviour:
- Reset (rstn low, async): state=IDLE; req_ready=0; resp_valid=0; resp_y=0; unit_en=0; unit_x1=0; busy=0; grant tag=0; round-robin pointer=0 (requester 0 highest priority).
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if unit_idle=1 and any req_valid, req_ready is driven combinationally one-hot to the winner.
  - Winner: first requester with req_valid, searching upward (with wrap) from pointer.
  - On accept: capture req_x1 into unit_x1, store the winner's index as tag, set pointer=(tag+1) mod NREQ, go to ISSUE.
  - If unit_idle=0: req_ready=0 and the state remains IDLE.
- ISSUE: unit_en=1 for exactly this cycle; unit_x1 stable; next state WAIT.
- WAIT: unit_en=0. On unit_valid=1, capture unit_y into resp_y and go to RESP.
- RESP: resp_valid[tag]=1 for one cycle; next state IDLE.
- Latency for a unit with valid 2 cycles after en:
  - accept cycle A, unit_en at A+1, unit_valid at A+3, resp_valid at A+4.
  - Next accept is possible at A+5.
- unit_valid outside WAIT is ignored: no state change, no response.
- Simultaneous requests: exactly one is granted per transaction. Non-granted requesters keep req_valid asserted. With all requesters active, grants rotate 0,1,...,NREQ-1,0.
- A single requester may be granted back-to-back when no other req_valid is high.
- req_ready is never high outside IDLE.
- At most one resp_valid bit is high in any cycle, and only one transaction is outstanding.
- Reset mid-operation: everything returns to reset values immediately and any in-flight result is dropped.
  - After reset, no issue occurs until unit_idle=1, so a unit still completing the old op is never double-started.
  - A stale unit_valid arriving after reset is ignored (state is IDLE).

Optional Feature:
- Macro: FPU_SHARE_ARB_TIMEOUT_EN.
- Defined:
  - Adds output resp_err (1 bit, reset 0) and a cycle counter cleared on entry to WAIT.
  - If the counter reaches TIMEOUT_CYCLES in WAIT without unit_valid, go to RESP with resp_y=32'h0000_0000 and resp_err=1, high only in that RESP cycle.
  - A late unit_valid is then ignored per the WAIT rule.
- Not defined: no resp_err port, no counter; WAIT holds indefinitely until unit_valid.

Test Plan:
- Single request: reset, unit_idle=1, req_valid[0]=1 with req_x1=32'h3FC0_0000 (1.5), unit models ftoi → req_ready[0] at cycle A, unit_en at A+1 with unit_x1=32'h3FC0_0000, resp_valid=2'b01 at A+4 with resp_y=2.
- Contention: NREQ=2, both req_valid held with x1=32'h4020_0000 (2.5) and 32'hC040_0000 (-3.0) → grant order 0 then 1; resp_y=3 then 32'hFFFF_FFFD; resp_valid pulses 2'b01 then 2'b10, never both high.
- Fairness: NREQ=4, all four requesters continuously valid for 8 transactions → grant sequence 0,1,2,3,0,1,2,3.
- Unit busy: unit_idle=0 for 5 cycles while req_valid[1]=1 → req_ready stays 0 and unit_en stays 0. Accept occurs the first cycle unit_idle=1.
- Mid-op reset: assert rstn=0 in WAIT, release, then inject unit_valid=1 → no resp_valid; busy=0; the next request is served normally starting from requester 0.
- Timeout (macro defined, TIMEOUT_CYCLES=16): unit never returns valid → resp_valid[tag]=1 with resp_err=1 and resp_y=0 after 16 cycles in WAIT, then return to IDLE.
